// File: rtl/mult_unit_pkg.sv
// mult_unit_pkg: shared constants for the sequential shift-add multiplier.
`default_nettype none

package mult_unit_pkg;

  localparam int MULT_WIDTH = 32;

  // Radix-2 retires one multiplier bit per RUN cycle.
  function automatic int iter_count(input int width);
    return width;
  endfunction

  localparam int ITER_COUNT = iter_count(MULT_WIDTH);

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_PREP = 3'd1;
  localparam logic [STATE_W-1:0] S_RUN  = 3'd2;
  localparam logic [STATE_W-1:0] S_FIX  = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/mult_unit_adder.sv
// ripple_adder32: WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

`default_nettype wire

// File: rtl/mult_unit.sv
// mult_unit: multi-cycle signed/unsigned WIDTH x WIDTH multiplier (radix-2 shift-add,
// fixed latency) producing a 2*WIDTH product split into hi/lo.
`default_nettype none

module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(iter_count(WIDTH) + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(iter_count(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [STATE_W-1:0] state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               sign;
  logic               op_signed;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   neg_sum;
  logic               neg_cout;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Main adder: shift-add steps in RUN, |a| in PREP, upper-half negation in FIX.
  always_comb begin
    add_a   = acc;
    add_b   = mplier[0] ? mcand : '0;
    add_cin = 1'b0;
    case (state)
      S_PREP: begin
        add_a   = ~mcand;
        add_b   = '0;
        add_cin = 1'b1;
      end
      S_FIX: begin
        add_a   = ~acc;
        add_b   = '0;
        add_cin = neg_cout;
      end
      default: ;
    endcase
  end

  ripple_adder32 #(.WIDTH(WIDTH)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Second instance negates the low word so FIX stays a single cycle; its carry
  // chains straight into the main adder for the upper half.
  ripple_adder32 #(.WIDTH(WIDTH)) u_neg (
    .a    (~mplier),
    .b    ('0),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      op_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand     <= a;
            mplier    <= b;
            op_signed <= is_signed;
            state     <= S_PREP;
          end
        end
        S_PREP: begin
          if (op_signed && mcand[WIDTH-1]) begin
            mcand <= add_sum;
          end
          if (op_signed && mplier[WIDTH-1]) begin
            mplier <= neg_sum;
          end
          sign  <= op_signed & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
          acc   <= '0;
          cnt   <= CNT_LOAD;
          state <= S_RUN;
        end
        S_RUN: begin
          acc    <= {add_cout, add_sum[WIDTH-1:1]};
          mplier <= {add_sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (sign) begin
            hi <= add_sum;
            lo <= neg_sum;
          end else begin
            hi <= acc;
            lo <= mplier;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
// tb_mult_unit: randomized and directed self-checking bench for mult_unit.
`default_nettype none

module tb_mult_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product straight from integer arithmetic, modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input bit sgn);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One operation; optionally pulses start again in cycle inj (0 = never).
  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb, input bit sgn,
                        input int inj, input string tag);
    logic [63:0] exp;
    logic [63:0] got;
    int          first;
    int          ndone;
    bit          busy_ok;
    int          window;
    exp     = ref_prod(opa, opb, sgn);
    first   = -1;
    ndone   = 0;
    busy_ok = 1'b1;
    got     = '0;
    window  = (inj != 0) ? LAT + 40 : LAT + 2;
    @(negedge clk);
    start = 1'b1; a = opa; b = opb; is_signed = sgn;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    for (int n = 1; n <= window; n++) begin
      @(negedge clk);
      start = (n == inj);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = n;
          got   = {hi, lo};
        end
      end
      if (n < LAT && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(first), 64'(LAT));
    chk({tag, " product"}, got, exp);
    chk({tag, " done count"}, 64'(ndone), 64'd1);
    chk({tag, " busy held"}, 64'(busy_ok), 64'd1);
    chk({tag, " hold"}, {hi, lo}, exp);
  endtask

  task automatic reset_mid_op();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; a = 32'h0BAD_F00D; b = 32'h0000_1234; is_signed = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi/lo", {hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < LAT + 10; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst no done", 64'(ndone), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 0, "after rst 2x3");
  endtask

  task automatic back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] res[2];
    int          cyc[2];
    int          ndone;
    bit          idle_seen;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    ndone = 0;
    idle_seen = 1'b0;
    res[0] = '0; res[1] = '0; cyc[0] = -1; cyc[1] = -1;
    @(negedge clk);
    start = 1'b1; a = a1; b = b1; is_signed = 1'b1;
    @(posedge clk);
    #1 a = a2; b = b2; is_signed = 1'b0;
    for (int n = 1; n <= 2 * LAT + 6; n++) begin
      @(negedge clk);
      if (n == LAT + 2) start = 1'b0;
      if (n == LAT + 1 && !busy) idle_seen = 1'b1;
      if (done) begin
        if (ndone < 2) begin
          res[ndone] = {hi, lo};
          cyc[ndone] = n;
        end
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b done count", 64'(ndone), 64'd2);
    chk("b2b idle gap", 64'(idle_seen), 64'd1);
    chk("b2b first cycle", 64'(cyc[0]), 64'(LAT));
    chk("b2b second cycle", 64'(cyc[1]), 64'(2 * LAT + 1));
    chk("b2b first product", res[0], ref_prod(a1, b1, 1'b1));
    chk("b2b second product", res[1], ref_prod(a2, b2, 1'b0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #3;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 0, "u 7x6");
    chk("u 7x6 literal", {hi, lo}, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "u max x max");
    chk("u max literal", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 0, "s -3x5");
    chk("s -3x5 literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s min x min");
    chk("s min literal", {hi, lo}, 64'h4000_0000_0000_0000);

    for (int i = 0; i < 16; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom), 0, $sformatf("rand %0d", i));
    end

    run_op($urandom, $urandom, 1'b1, 10, "start while busy");
    run_op($urandom, $urandom, 1'b0, LAT, "start in done");
    reset_mid_op();
    back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking hi/lo valid.
REQ-010 The block SHALL have port hi, output, WIDTH bits: upper half of the 2*WIDTH product.
REQ-011 The block SHALL have port lo, output, WIDTH bits: lower half of the 2*WIDTH product.

Function
REQ-012 The block SHALL implement the FSM states IDLE, PREP, RUN, FIX and DONE.
REQ-013 IDLE SHALL move to PREP when start=1, capturing a, b and is_signed; with start=0 it SHALL stay in IDLE.
REQ-014 PREP SHALL load the magnitudes |a| and |b| when is_signed=1, or the raw operands when is_signed=0.
REQ-015 PREP SHALL record the product sign as a[WIDTH-1] XOR b[WIDTH-1] when is_signed=1, else 0.
REQ-016 PREP SHALL clear the accumulator and load the iteration counter with WIDTH.
REQ-017 RUN SHALL do one radix-2 shift-add step per cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half via the WIDTH-bit adder, keeping the carry-out.
REQ-018 Each RUN step SHALL then shift {carry, accumulator, multiplier} right by one and decrement the counter.
REQ-019 RUN SHALL last exactly WIDTH cycles, then move to FIX.
REQ-020 FIX SHALL two's-complement negate the 2*WIDTH result when the recorded sign is 1, and pass it through unchanged otherwise; it then moves to DONE.
REQ-021 In DONE the block SHALL drive hi/lo with the final product and pulse done=1 for exactly one cycle; DONE then moves to IDLE.
REQ-022 Latency SHALL be fixed: with start sampled at edge 0, done SHALL be high in cycle WIDTH+3 (cycle 35 for WIDTH=32), independent of operand values.
REQ-023 start SHALL be ignored while busy=1; a start arriving in the same cycle that DONE is active SHALL also be ignored.
REQ-024 hi/lo SHALL update only on the edge entering DONE and hold until the next completed operation.
REQ-025 Negating the most negative value SHALL be handled with the unsigned magnitude 2^(WIDTH-1), with no overflow flag.
REQ-026 All arithmetic SHALL be modulo 2^(2*WIDTH); no exceptions SHALL be raised.

Reset
REQ-027 While rst=1 the state SHALL go to IDLE immediately, regardless of clk.
REQ-028 While rst=1 busy, done, hi, lo, the accumulator, counter and sign SHALL all go to 0.
REQ-029 A reset asserted mid-operation SHALL abandon that operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Structure
REQ-030 A shared package/header SHALL hold the state encodings, the default WIDTH and the iteration-count constant.
REQ-031 The adder SHALL be a separate sub-module, ripple_adder32: WIDTH-bit ripple-carry adder of one-bit full-adder cells, ports a, b, cin, sum, cout.
REQ-032 mult_unit SHALL instantiate ripple_adder32 once, reusing it for the RUN additions and the FIX negation (invert plus cin=1, two halves sequenced within FIX via a carry register).
REQ-033 The FIX negation MAY instead use a second adder instance if single-cycle FIX otherwise fails.

Verification
REQ-034 Unsigned 7 x 6 SHALL give hi=00000000, lo=0000002A, with done in cycle 35.
REQ-035 Unsigned FFFFFFFF x FFFFFFFF SHALL give hi=FFFFFFFE, lo=00000001.
REQ-036 Signed FFFFFFFD x 00000005 SHALL give hi=FFFFFFFF, lo=FFFFFFF1; signed 80000000 x 80000000 SHALL give hi=40000000, lo=00000000.
REQ-037 A start pulse in cycle 10 of an operation SHALL leave the first result intact, produce no second done, and keep busy continuously high until DONE.
REQ-038 rst asserted in cycle 12 SHALL take busy, hi and lo to 0 before the next clk edge; no done SHALL follow; a new 2 x 3 SHALL then give lo=00000006.
REQ-039 Back-to-back operations with start held high SHALL have the second start accepted in the IDLE cycle after DONE, with exactly one done per operation.
